// File: rtl/serial_comp_if.sv
// Handshake and result bundle for the bit-serial comparator.
// The master drives start/operands; the slave (comparator) returns status and results.
interface serial_comp_if #(
    parameter int WIDTH = 5,
    parameter int POS_W = 4
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [POS_W-1:0] diff_pos;

    modport master (
        output start, a_in, b_in,
        input  busy, done, eq, gt, lt, diff_pos
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, eq, gt, lt, diff_pos
    );
endinterface

// File: rtl/serial_comp.sv
// Bit-serial MSB-first magnitude/equality comparator; one operand bit pair per clock.
// Optional macro EARLY_EXIT_EN: finish the scan as soon as the first differing bit is seen.
module serial_comp #(
    parameter int WIDTH = 5,
    parameter int POS_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    serial_comp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, a_sr_nxt, b_sr_nxt;
    logic [POS_W-1:0] cnt, cnt_nxt;
    logic [POS_W-1:0] diff_pos_q, diff_pos_nxt;
    logic             found, found_nxt;
    logic             eq_q, gt_q, lt_q, eq_nxt, gt_nxt, lt_nxt;
    logic             busy_q, done_q, busy_nxt, done_nxt;
    logic             x, first_diff, leave;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.eq       = eq_q;
    assign bus.gt       = gt_q;
    assign bus.lt       = lt_q;
    assign bus.diff_pos = diff_pos_q;

    assign x          = a_sr[WIDTH-1] ^ b_sr[WIDTH-1];
    assign first_diff = x & ~found;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        a_sr_nxt     = a_sr;
        b_sr_nxt     = b_sr;
        cnt_nxt      = cnt;
        found_nxt    = found;
        diff_pos_nxt = diff_pos_q;
        eq_nxt       = eq_q;
        gt_nxt       = gt_q;
        lt_nxt       = lt_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        leave        = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt    = SHIFT;
                    a_sr_nxt     = bus.a_in;
                    b_sr_nxt     = bus.b_in;
                    cnt_nxt      = POS_W'(WIDTH - 1);
                    found_nxt    = 1'b0;
                    diff_pos_nxt = '0;
                    eq_nxt       = 1'b0;
                    gt_nxt       = 1'b0;
                    lt_nxt       = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end
            SHIFT: begin
                // Only the most significant differing bit decides gt/lt and diff_pos.
                if (first_diff) begin
                    found_nxt    = 1'b1;
                    diff_pos_nxt = cnt;
                    gt_nxt       = a_sr[WIDTH-1];
                    lt_nxt       = b_sr[WIDTH-1];
                end
                a_sr_nxt = a_sr << 1;
                b_sr_nxt = b_sr << 1;
                cnt_nxt  = cnt - 1'b1;
`ifdef EARLY_EXIT_EN
                leave = (cnt == '0) || first_diff;
`else
                leave = (cnt == '0);
`endif
                if (leave) begin
                    state_nxt = DONE;
                    eq_nxt    = ~(found | x);
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            // NOTE: the shift registers and counter are plain flops, so clearing them on reset is cheap and keeps state deterministic.
            a_sr       <= '0;
            b_sr       <= '0;
            cnt        <= '0;
            found      <= 1'b0;
            diff_pos_q <= '0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            a_sr       <= a_sr_nxt;
            b_sr       <= b_sr_nxt;
            cnt        <= cnt_nxt;
            found      <= found_nxt;
            diff_pos_q <= diff_pos_nxt;
            eq_q       <= eq_nxt;
            gt_q       <= gt_nxt;
            lt_q       <= lt_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
        end
    end
endmodule
